hello_streamer: RTL and testbench
=================================

// Module: hello_streamer
// PURPOSE
//  Parametrised greeting generator, successor to the per-clock hello printer.
//  - Emits a fixed ASCII message as a byte stream over a valid/ready handshake.
//  - Repeats the message with a programmable idle gap while enabled.
//  - Counts completed messages.
//  - Used as a heartbeat/liveness source and as a stream-sink test stimulus.
// PARAMETERS
//  MSG_LEN  14                 number of characters in message (>=1)
//  MSG      "Hello There !!"   message, 8*MSG_LEN bits, Verilog string packing
//  GAP      16                 idle cycles between last handshake and next first char (>=0)
//  CNT_W    16                 width of msg_count
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  rst        in   1      asynchronous, active-high reset
//  en         in   1      run enable, level-sensitive
//  out_data   out  8      current character
//  out_valid  out  1      out_data valid
//  out_ready  in   1      sink accepts when out_valid && out_ready (handshake)
//  out_last   out  1      high with the final character of a message
//  busy       out  1      high in SEND or WAIT
//  msg_count  out  CNT_W  completed messages, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - out_data=0, out_valid=0, out_last=0, busy=0, msg_count=0.
//   - state=IDLE, char index=0, gap timer=0.
//  FSM states: IDLE, SEND, WAIT. All outputs are registered.
//   IDLE: en sampled high at edge t -> SEND; first char valid from t+1.
//   SEND: out_valid=1, out_data=char[idx]. Order is MSG[8*MSG_LEN-1 -: 8] first.
//    - Handshake on a non-last char: idx+1; next char presented the following cycle.
//    - No bubbles while out_ready stays high.
//    - Handshake on idx==MSG_LEN-1 (out_last=1):
//      - msg_count+1; idx->0.
//      - GAP==0 and en=1: stay in SEND; new message starts next cycle.
//      - GAP>0 and en=1: -> WAIT; timer loaded with GAP.
//      - en=0: -> IDLE.
//   WAIT: out_valid=0, busy=1; timer decrements each cycle.
//    - Timer reaching 0 -> SEND, so the first char is valid exactly GAP cycles
//      after the last-handshake cycle plus one.
//    - en low in WAIT -> IDLE next edge; timer cleared.
//  Handshake rules:
//   - While out_valid && !out_ready, out_data and out_last are held stable.
//   - out_valid never drops without a handshake.
//   - en low mid-message does NOT truncate: the message completes, then IDLE.
//  out_last is 1 only when out_valid=1 and idx==MSG_LEN-1.
//  MSG_LEN==1: every char carries out_last.
//  busy = (state != IDLE).
//  Reset mid-message: immediate abort, all outputs to reset values.
//   - After release, the message restarts from char 0.
//  msg_count 2^CNT_W-1 +1 -> 0, no flag.
// CONFIGURATION
//  HELLO_STREAMER_MONITOR_EN defined:
//   - Simulation-only block prints "%g ns --> <MSG> #<n>" via $display
//     on each message-completing handshake; $time in ns.
//   - Wrapped in `ifdef; excluded from synthesis.
//  Not defined: no display code; RTL behaviour identical.
// TESTING
//  1 Assert rst for 3 cycles with en=1 -> all outputs 0 throughout;
//    msg_count=0; busy=0.
//  2 MSG_LEN=2, MSG="Hi", GAP=3, out_ready=1, en=1 from t0:
//    - valid 'H' at t1, 'i'+last at t2.
//    - valid low t3..t5; 'H' at t6.
//    - msg_count=1 after t2.
//  3 Default MSG, out_ready low for 5 cycles while 'l' presented ->
//    'l' held stable and valid; resumes with 'l','o' on ready.
//  4 Drop en after 3rd char handshake ->
//    remaining 11 chars still sent, last flagged, then IDLE, busy=0, msg_count+1.
//  5 Assert rst while 7th char valid ->
//    outputs 0 in the same cycle; after release with en=1, first char is 'H'.
//  6 GAP=0, CNT_W=2, ready=1 for 5 messages ->
//    - no idle cycle between messages.
//    - msg_count 1,2,3,0,1.
//    - with HELLO_STREAMER_MONITOR_EN defined, 5 display lines.

Source files
------------

// File: rtl/hello_streamer_if.sv
// Byte-stream handshake bundle for hello_streamer: data, valid and last flow
// from the master, and ready flows back from the slave.
`timescale 1ns/1ps
interface hello_streamer_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/hello_streamer.sv
// Greeting generator: streams MSG repeatedly over a valid/ready handshake with a
// GAP-cycle idle period between messages. Define HELLO_STREAMER_MONITOR_EN for a sim-only print.
`timescale 1ns/1ps
module hello_streamer #(
    parameter int                   MSG_LEN = 14,
    parameter logic [8*MSG_LEN-1:0] MSG     = "Hello There !!",
    parameter int                   GAP     = 16,
    parameter int                   CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    hello_streamer_if.master     out_if,
    output logic                 busy,
    output logic [CNT_W-1:0]     msg_count
);

    localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int TMR_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP);
    localparam logic             ONE_CHAR = (MSG_LEN == 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] idx_next;
    logic             handshake;

    // First character of the message sits in the most significant byte.
    function automatic logic [7:0] char_at(input logic [IDX_W-1:0] i);
        return MSG[8*(MSG_LEN - 1 - int'(i)) +: 8];
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        count_d   = count_q;
        idx_next  = idx_q + IDX_W'(1);
        handshake = valid_q && out_if.out_ready;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_SEND;
                    idx_d   = '0;
                    data_d  = char_at('0);
                    valid_d = 1'b1;
                    last_d  = ONE_CHAR;
                end
            end
            S_SEND: begin
                if (handshake) begin
                    if (idx_q == LAST_IDX) begin
                        count_d = count_q + CNT_W'(1);
                        idx_d   = '0;
                        if (!en) begin
                            state_d = S_IDLE;
                            data_d  = 8'h00;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                        end else if (GAP == 0) begin
                            data_d  = char_at('0);
                            valid_d = 1'b1;
                            last_d  = ONE_CHAR;
                        end else begin
                            state_d = S_WAIT;
                            timer_d = GAP_LOAD;
                            data_d  = 8'h00;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                        end
                    end else begin
                        idx_d  = idx_next;
                        data_d = char_at(idx_next);
                        last_d = (idx_next == LAST_IDX);
                    end
                end
            end
            S_WAIT: begin
                // Leaving on timer==1 puts the first char exactly GAP idle cycles after the last handshake.
                if (!en) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (timer_q <= TMR_W'(1)) begin
                    state_d = S_SEND;
                    timer_d = '0;
                    idx_d   = '0;
                    data_d  = char_at('0);
                    valid_d = 1'b1;
                    last_d  = ONE_CHAR;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                data_d  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            timer_q <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    assign out_if.out_data  = data_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_last  = last_q;
    assign busy             = (state_q != S_IDLE);
    assign msg_count        = count_q;

`ifdef HELLO_STREAMER_MONITOR_EN
    always @(posedge clk) begin
        if (!rst && valid_q && out_if.out_ready && last_q)
            $display("%g ns --> %s #%0d", $realtime, MSG, count_q + CNT_W'(1));
    end
`endif

endmodule

// File: tb/tb_hello_streamer.sv
// Directed bench for hello_streamer: three instances (default, "Hi"/GAP=3,
// GAP=0/CNT_W=2) driven on the falling edge and checked against hand-computed values.
`timescale 1ns/1ps
module tb_hello_streamer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_def = 1'b1;
    logic en_hi  = 1'b1;
    logic en_g0  = 1'b1;
    logic        busy_def, busy_hi, busy_g0;
    logic [15:0] cnt_def, cnt_hi;
    logic [1:0]  cnt_g0;

    int checks = 0;
    int errors = 0;
    string msg_s = "Hello There !!";
    string hi_s  = "Hi";

    hello_streamer_if if_def();
    hello_streamer_if if_hi();
    hello_streamer_if if_g0();

    hello_streamer dut_def (
        .clk(clk), .rst(rst), .en(en_def), .out_if(if_def.master),
        .busy(busy_def), .msg_count(cnt_def)
    );

    hello_streamer #(.MSG_LEN(2), .MSG("Hi"), .GAP(3), .CNT_W(16)) dut_hi (
        .clk(clk), .rst(rst), .en(en_hi), .out_if(if_hi.master),
        .busy(busy_hi), .msg_count(cnt_hi)
    );

    hello_streamer #(.GAP(0), .CNT_W(2)) dut_g0 (
        .clk(clk), .rst(rst), .en(en_g0), .out_if(if_g0.master),
        .busy(busy_g0), .msg_count(cnt_g0)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected "Hi" stream after reset release, one entry per falling edge.
    logic       hi_valid [1:8] = '{1, 1, 0, 0, 0, 1, 1, 0};
    logic       hi_last  [1:8] = '{0, 1, 0, 0, 0, 0, 1, 0};
    logic       hi_busy  [1:8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    logic [7:0] hi_data  [1:8] = '{"H", "i", 0, 0, 0, "H", "i", 0};
    int         hi_count [1:8] = '{0, 0, 1, 1, 1, 1, 1, 2};

    initial begin
        int idx;
        if_def.out_ready = 1'b1;
        if_hi.out_ready  = 1'b1;
        if_g0.out_ready  = 1'b1;

        $display("[TB] reset held with en high");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("rst_valid", 32'(if_def.out_valid), 32'd0);
            checkOutput("rst_data", 32'(if_def.out_data), 32'd0);
            checkOutput("rst_last", 32'(if_def.out_last), 32'd0);
            checkOutput("rst_busy", 32'(busy_def), 32'd0);
            checkOutput("rst_count", 32'(cnt_def), 32'd0);
            checkOutput("rst_hi_valid", 32'(if_hi.out_valid), 32'd0);
            checkOutput("rst_g0_busy", 32'(busy_g0), 32'd0);
        end
        en_def = 1'b0;
        en_g0  = 1'b0;
        rst    = 1'b0;

        $display("[TB] Hi with GAP=3");
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checkOutput($sformatf("hi_valid_%0d", k), 32'(if_hi.out_valid), 32'(hi_valid[k]));
            if (hi_valid[k])
                checkOutput($sformatf("hi_data_%0d", k), 32'(if_hi.out_data), 32'(hi_data[k]));
            checkOutput($sformatf("hi_last_%0d", k), 32'(if_hi.out_last), 32'(hi_last[k]));
            checkOutput($sformatf("hi_busy_%0d", k), 32'(busy_hi), 32'(hi_busy[k]));
            checkOutput($sformatf("hi_count_%0d", k), 32'(cnt_hi), 32'(hi_count[k]));
            if (k == 6) en_hi = 1'b0;
        end
        checkOutput("hi_str0", 32'(hi_s[0]), 32'(hi_data[1]));

        $display("[TB] backpressure on the first l");
        en_def = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            idx = (k < 3) ? k - 1 : ((k <= 8) ? 2 : k - 6);
            checkOutput($sformatf("bp_valid_%0d", k), 32'(if_def.out_valid), 32'd1);
            checkOutput($sformatf("bp_data_%0d", k), 32'(if_def.out_data), 32'(msg_s[idx]));
            checkOutput($sformatf("bp_last_%0d", k), 32'(if_def.out_last), 32'(idx == 13));
            if_def.out_ready = !(k >= 3 && k <= 7);
            if (k == 10) en_def = 1'b0;
        end
        @(negedge clk);
        checkOutput("bp_end_valid", 32'(if_def.out_valid), 32'd0);
        checkOutput("bp_end_busy", 32'(busy_def), 32'd0);
        checkOutput("bp_end_count", 32'(cnt_def), 32'd1);

        $display("[TB] en dropped after third handshake");
        en_def = 1'b1;
        for (int m = 1; m <= 14; m++) begin
            @(negedge clk);
            checkOutput($sformatf("drop_valid_%0d", m), 32'(if_def.out_valid), 32'd1);
            checkOutput($sformatf("drop_data_%0d", m), 32'(if_def.out_data), 32'(msg_s[m-1]));
            checkOutput($sformatf("drop_last_%0d", m), 32'(if_def.out_last), 32'(m == 14));
            checkOutput($sformatf("drop_busy_%0d", m), 32'(busy_def), 32'd1);
            if (m == 4) en_def = 1'b0;
        end
        @(negedge clk);
        checkOutput("drop_end_valid", 32'(if_def.out_valid), 32'd0);
        checkOutput("drop_end_last", 32'(if_def.out_last), 32'd0);
        checkOutput("drop_end_busy", 32'(busy_def), 32'd0);
        checkOutput("drop_end_count", 32'(cnt_def), 32'd2);

        $display("[TB] reset mid-message");
        en_def = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            checkOutput($sformatf("mid_data_%0d", n), 32'(if_def.out_data), 32'(msg_s[n-1]));
        end
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 32'(if_def.out_valid), 32'd0);
        checkOutput("mid_rst_data", 32'(if_def.out_data), 32'd0);
        checkOutput("mid_rst_last", 32'(if_def.out_last), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy_def), 32'd0);
        checkOutput("mid_rst_count", 32'(cnt_def), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("restart_valid", 32'(if_def.out_valid), 32'd1);
        checkOutput("restart_data", 32'(if_def.out_data), 32'("H"));
        en_def = 1'b0;

        $display("[TB] GAP=0 back-to-back, 2-bit counter");
        en_g0 = 1'b1;
        for (int m = 0; m < 70; m++) begin
            @(negedge clk);
            idx = m % 14;
            checkOutput($sformatf("g0_valid_%0d", m), 32'(if_g0.out_valid), 32'd1);
            checkOutput($sformatf("g0_data_%0d", m), 32'(if_g0.out_data), 32'(msg_s[idx]));
            checkOutput($sformatf("g0_last_%0d", m), 32'(if_g0.out_last), 32'(idx == 13));
            checkOutput($sformatf("g0_count_%0d", m), 32'(cnt_g0), 32'((m / 14) % 4));
            if (m == 69) en_g0 = 1'b0;
        end
        @(negedge clk);
        checkOutput("g0_end_count", 32'(cnt_g0), 32'd1);
        checkOutput("g0_end_busy", 32'(busy_g0), 32'd0);
        checkOutput("g0_end_valid", 32'(if_g0.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guards against a stalled run; the directed sequence needs only a few thousand ns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
